// File: rtl/cv32e40p_ex_muldiv_seq.sv
// cv32e40p_ex_muldiv_seq: iterative radix-2 RV32M multiply/divide sequencer with div-by-zero/overflow fast path
module cv32e40p_ex_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic [4:0]       waddr_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       waddr_o
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [4:0]         r_waddr;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg;
    logic               w_sa, w_sb, w_div0, w_ovf, w_accept, w_ge;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_qr, w_dres, w_res;
    logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_diff;
    logic [2*WIDTH-1:0] w_step, w_prod;
    assign w_sa     = operand_a_i[WIDTH-1] & (op_i != 3'd3) & (op_i != 3'd5) & (op_i != 3'd7);
    assign w_sb     = operand_b_i[WIDTH-1] & (op_i != 3'd2) & (op_i != 3'd3) & (op_i != 3'd5) & (op_i != 3'd7);
    assign w_a_abs  = w_sa ? -operand_a_i : operand_a_i;
    assign w_b_abs  = w_sb ? -operand_b_i : operand_b_i;
    assign w_div0   = op_i[2] & ~|operand_b_i;
    assign w_ovf    = op_i[2] & ~op_i[0] & (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&operand_b_i);
    assign w_accept = (r_state == IDLE) & en_i & ~flush_i;
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_step    = r_op[2] ? {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge}
                               : {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod   = r_neg ? -r_acc : r_acc;
    assign w_qr     = r_op[1] ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
    assign w_dres   = r_neg ? -w_qr : w_qr;
    assign w_res    = r_op[2] ? w_dres : (r_op == 3'd0 ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH]);
    assign ready_o        = (r_state == IDLE);
    assign busy_o         = (r_state != IDLE);
    assign result_valid_o = (r_state == FINISH);
    assign result_o       = (r_state == FINISH) ? w_res : {WIDTH{1'b0}};
    assign waddr_o        = r_waddr;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (flush_i) w_next = IDLE;
        else if (r_state == IDLE && en_i) w_next = (w_div0 || w_ovf) ? FINISH : CALC;
        else if (r_state == CALC && r_cnt == '0) w_next = FINISH;
        else if (r_state == FINISH && result_ready_i) w_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_waddr <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_neg   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= CW'(WIDTH-1);
            r_op    <= op_i;
            r_waddr <= waddr_i;
            r_b     <= op_i[2] ? w_b_abs : w_a_abs;
            r_neg   <= (w_div0 || w_ovf) ? 1'b0 : (op_i == 3'd6 ? w_sa : w_sa ^ w_sb);
            r_acc   <= w_div0 ? {operand_a_i, {WIDTH{1'b1}}}
                     : w_ovf  ? {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}}
                     : {{WIDTH{1'b0}}, (op_i[2] ? w_a_abs : w_b_abs)};
        end else if (r_state == CALC) begin
            r_acc <= w_step;
            r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule
